// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule and the
// encrypt/decrypt datapaths.
// Optional build macro used by importers: AES_KS_SBOX_PIPE_EN.
package aes_pkg;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    localparam int AES128_NR = 10;

    // Round constants; entry 0 is unused so rounds index directly.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise S-box substitution of a 32-bit word.
    function automatic aes_word_t sub_word(input aes_word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round constant for round r; out-of-range rounds yield 0.
    function automatic logic [7:0] rcon_byte(input logic [3:0] r);
        if (r <= 4'd10) begin
            return RCON[r];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_sched_128_if.sv
// Key-load and round-key read bus of the AES-128 key schedule.
//
// Handshake: a key transfers on a rising clk edge where key_valid and
// key_ready are both 1. key_ready does not depend on key_valid. While
// key_ready is 0 the key_valid/key pair is ignored; the master may hold it.
interface aes_key_sched_128_if;
    import aes_pkg::*;

    logic        key_valid;
    logic        key_ready;
    aes_block_t  key;
    logic        busy;
    logic        done;
    logic        sched_valid;
    logic [3:0]  rk_idx;
    aes_block_t  rk_data;
    aes_block_t  rk_last;
    logic [1:0]  fsm_state;

    modport master (
        output key_valid, key, rk_idx,
        input  key_ready, busy, done, sched_valid, rk_data, rk_last, fsm_state
    );

    modport slave (
        input  key_valid, key, rk_idx,
        output key_ready, busy, done, sched_valid, rk_data, rk_last, fsm_state
    );

endinterface

// File: rtl/aes_ks_round.sv
// One AES-128 key-expansion round. SubWord(RotWord(w3)) is exposed on
// sub_out and the mix step takes its substituted word from sub_in, so a
// register can sit between them when AES_KS_SBOX_PIPE_EN is defined.
module aes_ks_round
    import aes_pkg::*;
(
    input  aes_block_t prev_key,
    input  logic [7:0] rcon,
    input  aes_word_t  sub_in,
    output aes_word_t  sub_out,
    output aes_block_t next_key
);

    aes_word_t w0, w1, w2, w3;
    aes_word_t t, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;

    // Substitute the word rotated left by one byte.
    assign sub_out = sub_word({w3[23:0], w3[31:24]});

    // Chain the word XORs to form the next round key.
    always_comb begin
        t        = sub_in ^ {rcon, 24'h000000};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_128.sv
// Sequential AES-128 key expansion with an eleven-entry round-key bank.
// Build macro: AES_KS_SBOX_PIPE_EN registers the SubWord result so each
// round takes a sub-phase and a mix-phase (20 cycles instead of 10).
module aes_key_sched_128
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic                clk,
    input  logic                rst,
    aes_key_sched_128_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state;
    logic [3:0]  rnd;
    aes_block_t  work;
    aes_block_t  bank [0:NR];
    logic        done_q;
    logic        sched_valid_q;
    logic        accept;
    logic        step_en;
    aes_word_t   sub_raw;
    aes_word_t   sub_mix;
    aes_block_t  next_key;

    assign bus.key_ready   = (state != ST_EXPAND);
    assign bus.busy        = (state == ST_EXPAND);
    assign bus.done        = done_q;
    assign bus.sched_valid = sched_valid_q;
    assign bus.rk_last     = bank[NR];
    assign bus.fsm_state   = state;
    assign accept          = bus.key_valid && bus.key_ready;

    aes_ks_round u_round (
        .prev_key (work),
        .rcon     (rcon_byte(rnd)),
        .sub_in   (sub_mix),
        .sub_out  (sub_raw),
        .next_key (next_key)
    );

`ifdef AES_KS_SBOX_PIPE_EN
    logic      phase;
    aes_word_t sub_q;

    // Sub-phase captures the S-box output; mix-phase consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            sub_q <= '0;
        end else if (state == ST_EXPAND) begin
            phase <= ~phase;
            if (!phase) begin
                sub_q <= sub_raw;
            end
        end else begin
            phase <= 1'b0;
        end
    end

    assign step_en = phase;
    assign sub_mix = sub_q;
`else
    assign step_en = 1'b1;
    assign sub_mix = sub_raw;
`endif

    // Out-of-range read addresses return zero.
    always_comb begin
        bus.rk_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (bus.rk_idx == 4'(i)) begin
                bus.rk_data = bank[i];
            end
        end
    end

    // FSM, round counter, working key and bank updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rnd           <= 4'd0;
            work          <= '0;
            done_q        <= 1'b0;
            sched_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) begin
                bank[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        bank[0]       <= bus.key;
                        work          <= bus.key;
                        rnd           <= 4'd1;
                        sched_valid_q <= 1'b0;
                        state         <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    if (step_en) begin
                        bank[rnd] <= next_key;
                        work      <= next_key;
                        if (rnd == 4'(NR)) begin
                            state         <= ST_DONE;
                            done_q        <= 1'b1;
                            sched_valid_q <= 1'b1;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
